// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Two requesters share one registered adder. A three-state FSM (IDLE, CALC,
// RESULT) keeps at most one operation in flight. Ties go to the requester
// that did not win last time. Per-requester grant counters have sticky wrap
// flags.
//
// Ports
//   sys_clk, sys_reset_n            clock, asynchronous active-low reset
//   reqN_valid, reqN_a, reqN_b      requester N operand offer (N = 0, 1)
//   reqN_ready                      requester N transfer accepted this cycle
//   res_valid, res_sum, res_id      result (WIDTH+1 bit sum) and its owner
//   res_ready                       consumer accepts the result
//   stats_clear                     synchronous clear of counters and flags
//   grant_count0, grant_count1      accepted-transfer counts (wrapping)
//   count_overflow                  sticky wrap flag, bit N for requester N
//   busy                            high whenever the FSM is not IDLE
module adder_share_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset_n,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 res_valid,
    output logic [WIDTH:0]       res_sum,
    output logic                 res_id,
    input  logic                 res_ready,
    input  logic                 stats_clear,
    output logic [CNT_WIDTH-1:0] grant_count0,
    output logic [CNT_WIDTH-1:0] grant_count1,
    output logic [1:0]           count_overflow,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             id_reg;
    logic [WIDTH:0]   sum_reg;
    logic             res_id_reg;
    logic             last_grant_reg;
    logic             grant;
    logic             transfer;
    logic [1:0]       take_vec;

    // Winner among the currently valid requesters. On a tie the requester
    // that did not win the previous transfer gets it; with only one valid,
    // that one wins (req1_valid alone selects 1, otherwise 0).
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end
    end

    assign transfer = (state_reg == IDLE) && (req0_valid || req1_valid);

    // State register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (transfer) state_next = CALC;
            CALC:    state_next = RESULT;
            RESULT:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                busy       = 1'b0;
            end
            RESULT:  res_valid = 1'b1;
            default: ;
        endcase
    end

    assign take_vec = {req1_ready, req0_ready};

    // Operand capture on transfer, sum computed during CALC. The result
    // registers only change in CALC, so they hold steady through RESULT.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= 1'b0;
            sum_reg        <= '0;
            res_id_reg     <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            if (transfer) begin
                a_reg          <= grant ? req1_a : req0_a;
                b_reg          <= grant ? req1_b : req0_b;
                id_reg         <= grant;
                last_grant_reg <= grant;
            end
            if (state_reg == CALC) begin
                sum_reg    <= {1'b0, a_reg} + {1'b0, b_reg};
                res_id_reg <= id_reg;
            end
        end
    end

    assign res_sum = sum_reg;
    assign res_id  = res_id_reg;

    // Per-requester grant counters; clear takes priority over a coincident
    // transfer. The overflow flag sets on the all-ones to zero wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 ovf_reg;
            always_ff @(posedge sys_clk or negedge sys_reset_n) begin
                if (!sys_reset_n) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (stats_clear) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (take_vec[gi]) begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (&cnt_reg) begin
                        ovf_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign grant_count0   = g_cnt[0].cnt_reg;
    assign grant_count1   = g_cnt[1].cnt_reg;
    assign count_overflow = {g_cnt[1].ovf_reg, g_cnt[0].ovf_reg};

endmodule
